// File: rtl/time_entry_pkg.sv
// ============================================================================
//  Module   : time_entry_pkg
//  Purpose  : Shared types, limits and helpers for min:sec time entry
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package time_entry_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_MIN = 2'd1,
    EDIT_SEC = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  // One min or sec field, 0..59
  typedef logic [5:0] field_t;

  localparam field_t      MAX_MIN     = 6'd59;
  localparam field_t      MAX_SEC     = 6'd59;
  localparam logic [11:0] MAX_SECONDS = 12'd3599;
  localparam logic [11:0] SEC_PER_MIN = 12'd60;

  // Step a field up, wrapping past the maximum back to zero
  function automatic field_t wrap_inc(input field_t v, input field_t maxv);
    return (v == maxv) ? 6'd0 : v + 6'd1;
  endfunction

  // Step a field down, wrapping below zero to the maximum
  function automatic field_t wrap_dec(input field_t v, input field_t maxv);
    return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  // Fold {min,sec} back into total seconds at 12-bit width
  function automatic logic [11:0] to_seconds(input field_t mn, input field_t sc);
    return ({6'd0, mn} * SEC_PER_MIN) + {6'd0, sc};
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_event.sv
// ============================================================================
//  Module   : btn_event
//  Purpose  : Registers one debounced button, emits a pulse on its rising
//             edge and, optionally, auto-repeat pulses while it is held.
//             A held button seen while 'block' is high is locked out until
//             it has been released.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_event #(
  parameter bit          REPEAT_EN    = 1'b0,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn,
  input  logic block,
  output logic pulse
);

  logic btn_q;
  logic btn_prev;
  logic blocked;
  logic edge_det;
  logic rep_fire;

  assign edge_det = btn_q & ~btn_prev;

  // Input register, edge history and the hold-over lockout flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_q    <= 1'b0;
      btn_prev <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      btn_q    <= btn;
      btn_prev <= btn_q;
      blocked  <= btn_q & (blocked | block);
    end
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int unsigned MAXV = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int unsigned CW   = $clog2(MAXV + 1);
      localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
      localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

      logic [CW-1:0] hold_cnt;
      logic [CW-1:0] hold_cur;
      logic          repeating;

      // Hold count of the current cycle: zero on the edge cycle itself
      assign hold_cur = edge_det ? '0 : hold_cnt;
      assign rep_fire = btn_q & (repeating ? (hold_cur == RATE_C) : (hold_cur == DELAY_C));

      // Counts towards the initial delay, then restarts for each repeat period
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (!btn_q) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (rep_fire) begin
          hold_cnt  <= CW'(1);
          repeating <= 1'b1;
        end else begin
          hold_cnt  <= hold_cur + CW'(1);
        end
      end
    end else begin : g_no_repeat
      assign rep_fire = 1'b0;
    end
  endgenerate

  assign pulse = (edge_det | rep_fire) & ~blocked;

endmodule

`default_nettype wire

// File: rtl/time_entry.sv
// ============================================================================
//  Module   : time_entry
//  Purpose  : Button-driven min:sec editor; commits the edited value to the
//             timer as total seconds with a one-cycle load strobe.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_entry
  import time_entry_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [11:0] cur_time,
  input  logic        btn_edit,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  output logic        editing,
  output logic        field_sel,
  output logic [11:0] edit_value,
  output logic [11:0] time_out,
  output logic        time_load
);

  state_t      state;
  state_t      state_nxt;
  field_t      min_val;
  field_t      sec_val;
  field_t      min_nxt;
  field_t      sec_nxt;
  logic [11:0] time_nxt;
  logic        ev_edit;
  logic        ev_inc;
  logic        ev_dec;
  logic        ev_cancel;
  logic        in_idle;
  logic        step_up;
  logic        step_dn;

  // inc/dec held across a return to IDLE stay silent until re-pressed
  assign in_idle = (state == IDLE);

  btn_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_edit (
    .clk(clk), .nrst(nrst), .btn(btn_edit), .block(1'b0), .pulse(ev_edit)
  );
  btn_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_cancel (
    .clk(clk), .nrst(nrst), .btn(btn_cancel), .block(1'b0), .pulse(ev_cancel)
  );
  btn_event #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
    .clk(clk), .nrst(nrst), .btn(btn_inc), .block(in_idle), .pulse(ev_inc)
  );
  btn_event #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
    .clk(clk), .nrst(nrst), .btn(btn_dec), .block(in_idle), .pulse(ev_dec)
  );

  // Simultaneous inc and dec cancel each other
  assign step_up = ev_inc & ~ev_dec;
  assign step_dn = ev_dec & ~ev_inc;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and field updates; cancel beats edit beats inc/dec
  always_comb begin
    state_nxt = state;
    min_nxt   = min_val;
    sec_nxt   = sec_val;
    time_nxt  = time_out;
    case (state)
      IDLE: begin
        if (ev_edit) begin
          state_nxt = EDIT_MIN;
          if (cur_time > MAX_SECONDS) begin
            min_nxt = MAX_MIN;
            sec_nxt = MAX_SEC;
          end else begin
            min_nxt = field_t'(cur_time / SEC_PER_MIN);
            sec_nxt = field_t'(cur_time % SEC_PER_MIN);
          end
        end
      end
      EDIT_MIN: begin
        if (ev_cancel)    state_nxt = IDLE;
        else if (ev_edit) state_nxt = EDIT_SEC;
        else if (step_up) min_nxt   = wrap_inc(min_val, MAX_MIN);
        else if (step_dn) min_nxt   = wrap_dec(min_val, MAX_MIN);
      end
      EDIT_SEC: begin
        if (ev_cancel) begin
          state_nxt = IDLE;
        end else if (ev_edit) begin
          state_nxt = COMMIT;
          time_nxt  = to_seconds(min_val, sec_val);
        end else if (step_up) begin
          sec_nxt = wrap_inc(sec_val, MAX_SEC);
        end else if (step_dn) begin
          sec_nxt = wrap_dec(sec_val, MAX_SEC);
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Field registers, registered display copy and committed total
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      min_val    <= '0;
      sec_val    <= '0;
      edit_value <= '0;
      time_out   <= '0;
    end else begin
      min_val    <= min_nxt;
      sec_val    <= sec_nxt;
      edit_value <= {min_val, sec_val};
      time_out   <= time_nxt;
    end
  end

  // time_out is loaded on entry to COMMIT, so it is valid alongside the strobe
  assign editing   = (state == EDIT_MIN) || (state == EDIT_SEC);
  assign field_sel = (state == EDIT_SEC);
  assign time_load = (state == COMMIT);

endmodule

`default_nettype wire

// File: tb/tb_time_entry.sv
// ============================================================================
//  Module   : tb_time_entry
//  Purpose  : Self-checking bench for time_entry (scoreboard + reference model)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_entry;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [11:0] cur_time = '0;
  logic        btn_edit = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic        btn_cancel = 1'b0;
  logic        editing;
  logic        field_sel;
  logic [11:0] edit_value;
  logic [11:0] time_out;
  logic        time_load;

  time_entry #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
    .clk(clk), .nrst(nrst), .cur_time(cur_time),
    .btn_edit(btn_edit), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
    .editing(editing), .field_sel(field_sel), .edit_value(edit_value),
    .time_out(time_out), .time_load(time_load)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  // Reference model: mode 0 idle, 1 minutes, 2 seconds
  int m = 0, s = 0, mode = 0;
  bit prev_load = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every load strobe must match the oldest expected commit
  always @(negedge clk) begin
    if (nrst && time_load) begin
      chk("load_one_cycle", int'(prev_load), 0);
      if (exp_q.size() == 0) chk("unexpected_load", exp_q.size(), 1);
      else chk("time_out_at_load", int'(time_out), exp_q.pop_front());
    end
    prev_load = nrst && time_load;
  end

  // Model of one button event set {cancel,dec,inc,edit}
  task automatic model_op(input logic [3:0] mk);
    if (mode == 0) begin
      if (mk[0]) begin
        if (cur_time > 3599) begin m = 59; s = 59; end
        else begin m = cur_time / 60; s = cur_time % 60; end
        mode = 1;
      end
    end else if (mk[3]) begin
      mode = 0;
    end else if (mk[0]) begin
      if (mode == 1) mode = 2;
      else begin exp_q.push_back(m * 60 + s); mode = 0; end
    end else if (mk[1] != mk[2]) begin
      if (mode == 1) m = mk[1] ? (m + 1) % 60 : (m + 59) % 60;
      else           s = mk[1] ? (s + 1) % 60 : (s + 59) % 60;
    end
  endtask

  task automatic check_view();
    chk("editing", int'(editing), int'(mode != 0));
    chk("field_sel", int'(field_sel), int'(mode == 2));
    chk("edit_value", int'(edit_value), m * 64 + s);
  endtask

  // One-cycle press of the buttons in mk, then settle and check
  task automatic press(input logic [3:0] mk);
    {btn_cancel, btn_dec, btn_inc, btn_edit} = mk;
    model_op(mk);
    @(negedge clk);
    {btn_cancel, btn_dec, btn_inc, btn_edit} = 4'b0000;
    repeat (3) @(negedge clk);
    check_view();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mk;
    #1;
    chk("reset_editing", int'(editing), 0);
    chk("reset_time_out", int'(time_out), 0);
    chk("reset_time_load", int'(time_load), 0);
    chk("reset_edit_value", int'(edit_value), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Basic edit and commit of 2:05 + 3 s
    cur_time = 12'd125;
    press(4'b0001);
    chk("t1_edit_value", int'(edit_value), 'h085);
    press(4'b0001);
    repeat (3) press(4'b0010);
    press(4'b0001);
    chk("t1_time_out_hold", int'(time_out), 128);

    // Wrap of seconds and of minutes
    cur_time = 12'd59;
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    chk("t2_sec_wrap", int'(edit_value), 0);
    press(4'b1000);
    cur_time = 12'd0;
    press(4'b0001);
    press(4'b0100);
    chk("t2_min_wrap", int'(edit_value), 59 * 64);
    press(4'b1000);

    // Auto-repeat: 10 registered-high cycles give 4 events
    cur_time = 12'd0;
    press(4'b0001);
    press(4'b0001);
    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    s = (s + 4) % 60;
    repeat (3) @(negedge clk);
    check_view();
    chk("t3_repeat_sec", int'(edit_value), 4);
    press(4'b0010);
    chk("t3_repress_sec", int'(edit_value), 5);

    // Cancel beats edit; inc+dec together do nothing
    press(4'b1001);
    chk("t4_time_out_kept", int'(time_out), 128);
    cur_time = 12'd200;
    press(4'b0001);
    press(4'b0110);
    chk("t4_incdec_none", int'(edit_value), 3 * 64 + 20);
    press(4'b1000);

    // Clamp of an out-of-range current time
    cur_time = 12'd4000;
    press(4'b0001);
    chk("t5_clamp", int'(edit_value), 'hEFB);
    press(4'b0001);
    press(4'b0001);
    chk("t5_time_out", int'(time_out), 3599);

    // Asynchronous reset in the middle of an edit
    press(4'b0001);
    #2 nrst = 1'b0;
    #1;
    chk("t6_editing", int'(editing), 0);
    chk("t6_field_sel", int'(field_sel), 0);
    chk("t6_edit_value", int'(edit_value), 0);
    chk("t6_time_out", int'(time_out), 0);
    chk("t6_time_load", int'(time_load), 0);
    m = 0; s = 0; mode = 0;
    @(negedge clk);
    btn_inc = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    check_view();
    btn_inc = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized button traffic against the model
    for (int k = 0; k < 80; k++) begin
      if (mode == 0) begin
        cur_time = 12'($urandom_range(0, 4095));
        press(4'b0001);
      end else begin
        mk = 4'($urandom_range(1, 15));
        if (mk[3] && ($urandom_range(0, 3) != 0)) mk[3] = 1'b0;
        if (mk == 4'b0000) mk = 4'b0010;
        press(mk);
      end
    end

    repeat (5) @(negedge clk);
    chk("pending_loads", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/time_entry.md
Name: time_entry

Overview:
- Lets the user set a countdown value in min:sec with the existing push buttons, then hands the result to the timer counter as total seconds.
- Inverse of the display path: the display path converts seconds into {min,sec}; this block converts a user-edited {min,sec} back into seconds.
- Sits between the debounced button front end and the timer's load port.
- Drives the display mux with the value being edited while editing is in progress.

Parameters:
- REPEAT_DELAY, 25_000_000: clock cycles a button must be held before auto-repeat starts. Must be ≥ 2.
- REPEAT_RATE, 5_000_000: clock cycles between auto-repeat events once repeating. Must be ≥ 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- cur_time  in  12  current timer value in seconds; sampled when an edit starts
- btn_edit  in  1  debounced level; rising edge starts an edit, or advances to the next field
- btn_inc  in  1  debounced level; increment the active field
- btn_dec  in  1  debounced level; decrement the active field
- btn_cancel  in  1  debounced level; rising edge abandons the edit
- editing  out  1  high while in EDIT_MIN or EDIT_SEC
- field_sel  out  1  0 = minutes active, 1 = seconds active; used by the display for blinking
- edit_value  out  12  {min[5:0], sec[5:0]} of the value being edited
- time_out  out  12  committed total seconds
- time_load  out  1  one-cycle strobe; time_out is valid in the same cycle

Behaviour:
- Reset (asynchronous, nrst low), all values immediate:
  - state = IDLE
  - every output = 0
  - min = 0, sec = 0
  - all button history and repeat counters cleared
- Button inputs:
  - Each button is registered once.
  - An edge event fires in the cycle where the registered value is 1 and the previous registered value was 0.
- Auto-repeat, btn_inc and btn_dec only:
  - A hold counter starts at 0 on the edge cycle and increments each cycle the button stays high.
  - Extra events fire when hold count = REPEAT_DELAY, then every REPEAT_RATE cycles after that.
  - Release clears the counter.
- Event priority within one cycle: cancel > edit > inc/dec.
  - inc and dec together cancel out: no change.
- States:
  - IDLE:
    - On an edit event, load min = cur_time/60 and sec = cur_time%60, then go to EDIT_MIN.
    - If cur_time > 3599, load 59:59 instead.
    - inc, dec and cancel are ignored.
  - EDIT_MIN:
    - inc: min = (min == 59) ? 0 : min + 1.
    - dec: min = (min == 0) ? 59 : min − 1.
    - edit → EDIT_SEC.
    - cancel → IDLE, with no load.
  - EDIT_SEC:
    - inc and dec wrap 0..59 the same way as EDIT_MIN.
    - There is no carry or borrow into minutes.
    - edit → COMMIT.
    - cancel → IDLE.
  - COMMIT (one cycle):
    - time_out = min*60 + sec, computed at 12-bit width; maximum 3599.
    - time_load = 1.
    - Next state is IDLE unconditionally; button events in this cycle are dropped.
- Output values:
  - time_out holds its value after commit and changes only at the next commit.
  - editing and field_sel are decoded from the state register.
  - field_sel = 0 in IDLE.
  - edit_value is registered and tracks min/sec with 1-cycle latency from the update edge.
- Latency from a registered edge event:
  - Field value updates on the next clock edge.
  - edit_value reflects the update one edge after that.
- Buttons already held when IDLE is entered produce no events until released and pressed again. Edges only; a held inc keeps repeating only within the EDIT states.
- Reset mid-edit returns to IDLE immediately. There is no time_load, and time_out = 0.

Decomposition:
- Package time_entry_pkg:
  - state enum {IDLE, EDIT_MIN, EDIT_SEC, COMMIT}
  - MAX_MIN = 59, MAX_SEC = 59, MAX_SECONDS = 3599, SEC_PER_MIN = 60
  - field_t
- Sub-module btn_event:
  - Register, edge detect and optional auto-repeat counter.
  - Parameters REPEAT_EN, REPEAT_DELAY, REPEAT_RATE.
  - Instantiated four times: repeat on for inc/dec, off for edit/cancel.

Test Plan (REPEAT_DELAY=4, REPEAT_RATE=2 for sim):
1. cur_time=125, pulse btn_edit → editing=1, field_sel=0, edit_value=12'h085 (2:05); edit, inc×3, edit → time_load for exactly 1 cycle with time_out=128, then editing=0.
2. Wrap: load 0:59, go to EDIT_SEC, inc → 0:00 with min still 0; go to EDIT_MIN at 0, dec → 59.
3. Auto-repeat: in EDIT_SEC from sec=0, hold btn_inc for 10 registered-high cycles → events at hold counts 0, 4, 6, 8 → sec=4; release and press again → sec=5.
4. Cancel and priority:
   - From EDIT_SEC, assert btn_cancel and btn_edit in the same cycle → IDLE, no time_load, time_out unchanged.
   - inc+dec in the same cycle → field unchanged.
5. Clamp: cur_time=4000, start edit → edit_value = {6'd59,6'd59}; commit unchanged → time_out=3599.
6. Async reset: drop nrst mid-edit, off any clock edge → all outputs 0 immediately, state IDLE; after release, a held btn_inc produces no event.
